// File: rtl/register_file_cfg.sv
// register_file_cfg
// Configuration register file that sits between the system controller and the
// UART/prescaler config consumers. It has one write port and one read port,
// and both are serviced in the same cycle. Each register has its own reset
// value. The file also provides a read-only mask, range checking with error
// pulses, and change-notification pulses for the exported registers.
//
// Optional feature macro: PARITY_CHECK_EN. When it is defined, each register
// carries an even-parity bit, each read checks it, and a mismatch is reported
// on o_rd_parity_err.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          asynchronous reset, active low
//   i_wr_en          write request
//   i_wr_addr        write address
//   i_wr_data        write data
//   i_rd_en          read request
//   i_rd_addr        read address
//   o_rd_data        read data, registered; holds its value between reads
//   o_rd_valid       one-cycle pulse, o_rd_data is valid
//   o_rd_err         pulses with o_rd_valid when the read address is out of
//                    range (or on a parity mismatch)
//   o_wr_err         one-cycle pulse, the write was rejected
//   o_cfg_regs       live contents of registers 0..NUM_CFG_OUTS-1, flattened
//   o_cfg_changed    bit i pulses when an accepted write changed register i
//   o_rd_parity_err  (PARITY_CHECK_EN only) pulses with o_rd_valid on a
//                    parity mismatch
module register_file_cfg #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int NUM_CFG_OUTS = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] RESET_VALUES =
        ((DEPTH*DATA_WIDTH)'(1) << (2*DATA_WIDTH)) |
        ((DEPTH*DATA_WIDTH)'(8) << (3*DATA_WIDTH)),
    parameter logic [DEPTH-1:0] RO_MASK = '0
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_wr_en,
    input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
    input  logic [DATA_WIDTH-1:0]              i_wr_data,
    input  logic                               i_rd_en,
    input  logic [ADDR_WIDTH-1:0]              i_rd_addr,
    output logic [DATA_WIDTH-1:0]              o_rd_data,
    output logic                               o_rd_valid,
    output logic                               o_rd_err,
    output logic                               o_wr_err,
    output logic [NUM_CFG_OUTS*DATA_WIDTH-1:0] o_cfg_regs,
    output logic [NUM_CFG_OUTS-1:0]            o_cfg_changed
`ifdef PARITY_CHECK_EN
    ,
    output logic                               o_rd_parity_err
`endif
);

    localparam int ASPACE = 2 ** ADDR_WIDTH;
    // The mask is widened to the full address space so that an out-of-range
    // address can index it safely. The upper bits are never used to accept
    // a write.
    localparam logic [ASPACE-1:0] RO_EXT = ASPACE'(RO_MASK);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_ok;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_rd_stored;

    generate
        if (DEPTH == ASPACE) begin : g_full_space
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_partial_space
            localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
            assign w_wr_in_range = (i_wr_addr <= LAST);
            assign w_rd_in_range = (i_rd_addr <= LAST);
        end
    endgenerate

    assign w_wr_ok  = i_wr_en && w_wr_in_range && !RO_EXT[i_wr_addr];
    // When the read and the accepted write target the same address, the read
    // returns the new data.
    assign w_bypass = w_wr_ok && (i_wr_addr == i_rd_addr);

`ifdef PARITY_CHECK_EN
    logic [DEPTH-1:0] r_par;
    logic             w_rd_par;
    logic             w_par_err;
`endif

    // The read mux is a decode loop, so an out-of-range address returns zero
    // and never indexes past the array.
    always_comb begin
        w_rd_stored = '0;
`ifdef PARITY_CHECK_EN
        w_rd_par = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_addr == ADDR_WIDTH'(i)) begin
                w_rd_stored = r_mem[i];
`ifdef PARITY_CHECK_EN
                w_rd_par = r_par[i];
`endif
            end
        end
    end

`ifdef PARITY_CHECK_EN
    assign w_par_err = w_rd_in_range && !w_bypass && ((^w_rd_stored) != w_rd_par);
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef PARITY_CHECK_EN
                r_par[i] <= ^RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
`endif
            end
            o_rd_data     <= '0;
            o_rd_valid    <= 1'b0;
            o_rd_err      <= 1'b0;
            o_wr_err      <= 1'b0;
            o_cfg_changed <= '0;
`ifdef PARITY_CHECK_EN
            o_rd_parity_err <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_ok && (i_wr_addr == ADDR_WIDTH'(i))) begin
                    r_mem[i] <= i_wr_data;
`ifdef PARITY_CHECK_EN
                    r_par[i] <= ^i_wr_data;
`endif
                end
            end
            for (int i = 0; i < NUM_CFG_OUTS; i++) begin
                o_cfg_changed[i] <= w_wr_ok && (i_wr_addr == ADDR_WIDTH'(i)) &&
                                    (i_wr_data != r_mem[i]);
            end
            o_wr_err   <= i_wr_en && !w_wr_ok;
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_rd_data <= !w_rd_in_range ? '0 :
                             (w_bypass ? i_wr_data : w_rd_stored);
`ifdef PARITY_CHECK_EN
                o_rd_err        <= !w_rd_in_range || w_par_err;
                o_rd_parity_err <= w_par_err;
`else
                o_rd_err <= !w_rd_in_range;
`endif
            end else begin
                o_rd_err <= 1'b0;
`ifdef PARITY_CHECK_EN
                o_rd_parity_err <= 1'b0;
`endif
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CFG_OUTS; g++) begin : g_cfg_out
            assign o_cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
        end
    endgenerate

endmodule

// File: tb/tb_register_file_cfg.sv
// Testbench for register_file_cfg
// DUT configuration: DEPTH=12 with register 2 read-only.
module tb_register_file_cfg;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int NCFG  = 4;
    localparam logic [DEPTH-1:0] RO   = 12'h004;
    localparam logic [15:0]      RO16 = 16'h0004;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rd_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;
    logic               rd_valid;
    logic               rd_err;
    logic               wr_err;
    logic [NCFG*DW-1:0] cfg_regs;
    logic [NCFG-1:0]    cfg_changed;
`ifdef PARITY_CHECK_EN
    logic               rd_parity_err;
`endif

    register_file_cfg #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .NUM_CFG_OUTS (NCFG),
        .RO_MASK      (RO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_rd_en       (rd_en),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_rd_err      (rd_err),
        .o_wr_err      (wr_err),
        .o_cfg_regs    (cfg_regs),
        .o_cfg_changed (cfg_changed)
`ifdef PARITY_CHECK_EN
        ,
        .o_rd_parity_err (rd_parity_err)
`endif
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] m_regs [DEPTH];
    logic [DW-1:0] m_last_rd;
    logic          exp_valid;
    logic          exp_wr_err;
    logic [NCFG-1:0] exp_chg;
    rd_exp_t       sb [$];

    function automatic logic [DW-1:0] reset_val(input int i);
        case (i)
            2:       return 8'h01;
            3:       return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = reset_val(i);
        m_last_rd = '0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus and work out what the next cycle must show.
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra);
        logic    ok;
        rd_exp_t e;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        ok = we && (int'(wa) < DEPTH) && !RO16[wa];
        exp_wr_err = we && !ok;
        exp_chg = '0;
        if (ok && int'(wa) < NCFG && m_regs[wa] != wd) exp_chg[wa[1:0]] = 1'b1;
        exp_valid = re;
        if (re) begin
            if (int'(ra) >= DEPTH) begin
                e.data = '0; e.err = 1'b1;
            end else if (ok && wa == ra) begin
                e.data = wd; e.err = 1'b0;
            end else begin
                e.data = m_regs[ra]; e.err = 1'b0;
            end
            sb.push_back(e);
            m_last_rd = e.data;
        end
        if (ok) m_regs[wa] = wd;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_data, rd_valid, rd_err, wr_err, cfg_changed} !== 15'h0)
            $display("FAIL reset outputs: got data %h v %b re %b we %b chg %b want all zero",
                     rd_data, rd_valid, rd_err, wr_err, cfg_changed);
        else n_pass++;
        n_checks++;
        if (cfg_regs !== 32'h0801_0000)
            $display("FAIL reset cfg_regs: got %h want 08010000", cfg_regs);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_reads;
        rd_exp_t e;
        for (int k = 0; k <= DEPTH; k++) begin
            if (k < DEPTH) drive(0, '0, '0, 1, AW'(k));
            else           drive(0, '0, '0, 0, '0);
            tick();
            n_checks++;
            if (rd_valid !== exp_valid) $display("FAIL reset_reads[%0d] rd_valid: got %b want %b", k, rd_valid, exp_valid);
            else n_pass++;
            if (rd_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL reset_reads[%0d] rd_valid with empty scoreboard", k);
                else begin
                    e = sb.pop_front();
                    if (rd_data !== e.data || rd_err !== e.err)
                        $display("FAIL reset_reads[%0d] read: got %h/%b want %h/%b", k, rd_data, rd_err, e.data, e.err);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (rd_data !== m_last_rd || rd_err !== 1'b0)
                    $display("FAIL reset_reads[%0d] hold: got %h/%b want %h/0", k, rd_data, rd_err, m_last_rd);
                else n_pass++;
            end
            n_checks++;
            if (cfg_regs !== 32'h0801_0000) $display("FAIL reset_reads[%0d] cfg_regs: got %h want 08010000", k, cfg_regs);
            else n_pass++;
        end
    endtask

    task automatic test_change_notify;
        rd_exp_t e;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: drive(1, 4'd1, 8'hA5, 0, '0);
                1: drive(1, 4'd1, 8'hA5, 0, '0);
                2: drive(1, 4'd3, 8'h5A, 1, 4'd1);
                3: drive(1, 4'd0, 8'h00, 0, '0);
                4: drive(1, 4'd7, 8'h11, 0, '0);
                default: drive(0, '0, '0, 0, '0);
            endcase
            tick();
            n_checks++;
            if (rd_valid !== exp_valid) $display("FAIL change_notify[%0d] rd_valid: got %b want %b", k, rd_valid, exp_valid);
            else n_pass++;
            if (rd_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL change_notify[%0d] rd_valid with empty scoreboard", k);
                else begin
                    e = sb.pop_front();
                    if (rd_data !== e.data || rd_err !== e.err)
                        $display("FAIL change_notify[%0d] read: got %h/%b want %h/%b", k, rd_data, rd_err, e.data, e.err);
                    else n_pass++;
                end
            end
            n_checks++;
            if (wr_err !== exp_wr_err) $display("FAIL change_notify[%0d] wr_err: got %b want %b", k, wr_err, exp_wr_err);
            else n_pass++;
            n_checks++;
            if (cfg_changed !== exp_chg) $display("FAIL change_notify[%0d] cfg_changed: got %b want %b", k, cfg_changed, exp_chg);
            else n_pass++;
            n_checks++;
            if (cfg_regs !== {m_regs[3], m_regs[2], m_regs[1], m_regs[0]})
                $display("FAIL change_notify[%0d] cfg_regs: got %h want %h", k, cfg_regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            else n_pass++;
        end
    endtask

    task automatic test_collisions_and_rejects;
        rd_exp_t e;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: drive(1, 4'd5,  8'h3C, 1, 4'd5);
                1: drive(1, 4'd2,  8'hFF, 1, 4'd2);
                2: drive(1, 4'd13, 8'hFF, 1, 4'd13);
                3: drive(1, 4'd2,  8'hFF, 0, '0);
                4: drive(0, '0,    '0,    1, 4'd2);
                5: drive(1, 4'd11, 8'h77, 1, 4'd12);
                6: drive(1, 4'd1,  8'h44, 1, 4'd11);
                default: drive(0, '0, '0, 0, '0);
            endcase
            tick();
            n_checks++;
            if (rd_valid !== exp_valid) $display("FAIL collide[%0d] rd_valid: got %b want %b", k, rd_valid, exp_valid);
            else n_pass++;
            if (rd_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL collide[%0d] rd_valid with empty scoreboard", k);
                else begin
                    e = sb.pop_front();
                    if (rd_data !== e.data || rd_err !== e.err)
                        $display("FAIL collide[%0d] read: got %h/%b want %h/%b", k, rd_data, rd_err, e.data, e.err);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (rd_data !== m_last_rd || rd_err !== 1'b0)
                    $display("FAIL collide[%0d] hold: got %h/%b want %h/0", k, rd_data, rd_err, m_last_rd);
                else n_pass++;
            end
            n_checks++;
            if (wr_err !== exp_wr_err) $display("FAIL collide[%0d] wr_err: got %b want %b", k, wr_err, exp_wr_err);
            else n_pass++;
            n_checks++;
            if (cfg_changed !== exp_chg) $display("FAIL collide[%0d] cfg_changed: got %b want %b", k, cfg_changed, exp_chg);
            else n_pass++;
            n_checks++;
            if (cfg_regs !== {m_regs[3], m_regs[2], m_regs[1], m_regs[0]})
                $display("FAIL collide[%0d] cfg_regs: got %h want %h", k, cfg_regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        rd_exp_t       e;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        for (int k = 0; k < 80; k++) begin
            wa = AW'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
            if (k < 79) drive(1'($urandom_range(0, 1)), wa, 8'($urandom), 1'($urandom_range(0, 1)), ra);
            else        drive(0, '0, '0, 0, '0);
            tick();
            n_checks++;
            if (rd_valid !== exp_valid) $display("FAIL b2b[%0d] rd_valid: got %b want %b", k, rd_valid, exp_valid);
            else n_pass++;
            if (rd_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL b2b[%0d] rd_valid with empty scoreboard", k);
                else begin
                    e = sb.pop_front();
                    if (rd_data !== e.data || rd_err !== e.err)
                        $display("FAIL b2b[%0d] read: got %h/%b want %h/%b", k, rd_data, rd_err, e.data, e.err);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (rd_data !== m_last_rd || rd_err !== 1'b0)
                    $display("FAIL b2b[%0d] hold: got %h/%b want %h/0", k, rd_data, rd_err, m_last_rd);
                else n_pass++;
            end
            n_checks++;
            if (wr_err !== exp_wr_err) $display("FAIL b2b[%0d] wr_err: got %b want %b", k, wr_err, exp_wr_err);
            else n_pass++;
            n_checks++;
            if (cfg_changed !== exp_chg) $display("FAIL b2b[%0d] cfg_changed: got %b want %b", k, cfg_changed, exp_chg);
            else n_pass++;
            n_checks++;
            if (cfg_regs !== {m_regs[3], m_regs[2], m_regs[1], m_regs[0]})
                $display("FAIL b2b[%0d] cfg_regs: got %h want %h", k, cfg_regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            else n_pass++;
        end
    endtask

    task automatic test_reset_squash;
        wr_en = 1'b0;
        rd_en = 1'b1;
        rd_addr = 4'd3;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rd_data, rd_valid, rd_err, wr_err, cfg_changed} !== 15'h0)
            $display("FAIL squash outputs: got data %h v %b re %b we %b chg %b want all zero",
                     rd_data, rd_valid, rd_err, wr_err, cfg_changed);
        else n_pass++;
        rd_en = 1'b0;
        model_reset();
        rst_n = 1'b1;
        tick();
        test_reset_reads();
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity;
        dut.r_mem[4] = m_regs[4] ^ 8'h01;
        m_regs[4] = m_regs[4] ^ 8'h01;
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd4;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_parity_err !== 1'b1 || rd_data !== m_regs[4])
            $display("FAIL parity flip: got v %b re %b pe %b data %h want 1 1 1 %h",
                     rd_valid, rd_err, rd_parity_err, rd_data, m_regs[4]);
        else n_pass++;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h6B; rd_addr = 4'd4;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_parity_err !== 1'b0 || rd_data !== 8'h6B)
            $display("FAIL parity bypass: got v %b re %b pe %b data %h want 1 0 0 6b",
                     rd_valid, rd_err, rd_parity_err, rd_data);
        else n_pass++;
        m_regs[4] = 8'h6B;
        wr_en = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_parity_err !== 1'b0 || rd_data !== 8'h6B)
            $display("FAIL parity rewrite: got v %b re %b pe %b data %h want 1 0 0 6b",
                     rd_valid, rd_err, rd_parity_err, rd_data);
        else n_pass++;
        rd_en = 1'b0;
        m_last_rd = 8'h6B;
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_reads();
        test_change_notify();
        test_collisions_and_rejects();
        test_back_to_back();
        test_reset_squash();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
